// File: rtl/if2_fetch_stage_if.sv
// if2_fetch_stage_if: instruction-memory request/response bus plus the IF2->decode handoff.
// master is the fetch-stage view; slave is the memory/decode side.
interface if2_fetch_stage_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid_if2;
  logic [31:0] inst_if2;
  logic [31:0] pc_if2;
  logic        inst_ready_id;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output inst_valid_if2, inst_if2, pc_if2,
    input  inst_ready_id
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  inst_valid_if2, inst_if2, pc_if2,
    output inst_ready_id
  );
endinterface

// File: rtl/if2_fetch_stage.sv
// if2_fetch_stage: issues in-order imem requests from the IF1 PC and buffers returned words for
// decode. Define FETCH_STALL_CNT_EN to add the saturating fetch_stall_cnt output.
module if2_fetch_stage #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned OUTST_W    = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       current_pc_if1,
  output logic [31:0]       next_pc_if1,
  output logic              pc_en,
  input  logic              flush,
  input  logic [31:0]       flush_target,
`ifdef FETCH_STALL_CNT_EN
  output logic [31:0]       fetch_stall_cnt,
`endif
  if2_fetch_stage_if.master bus
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned SumW = ((OUTST_W > CntW) ? OUTST_W : CntW) + 1;

  logic [CntW-1:0]    count_q, count_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_next;
  logic [31:0]        inst_mem_q [FIFO_DEPTH];
  logic [31:0]        pc_mem_q   [FIFO_DEPTH];
  logic [31:0]        head_inst_q, head_inst_d, head_pc_q, head_pc_d;
  logic [OUTST_W-1:0] outst_q, outst_d, drop_cnt_q, drop_cnt_d;
  logic [31:0]        pcq_mem_q  [FIFO_DEPTH];
  logic [PtrW-1:0]    pcq_rd_q, pcq_rd_d, pcq_wr_q, pcq_wr_d;
  logic [SumW-1:0]    credit_sum;
  logic               req_valid, fire, rsp, enq, deq, inst_valid;

  // Credit uses registered state only, so a same-cycle pop never opens a slot.
  always_comb begin
    credit_sum  = SumW'(outst_q) + SumW'(count_q);
    req_valid   = reset_n && !flush && (credit_sum < SumW'(FIFO_DEPTH));
    fire        = req_valid && bus.imem_req_ready;
    rsp         = reset_n && bus.imem_rsp_valid;
    enq         = rsp && !flush && (drop_cnt_q == '0);
    inst_valid  = (count_q != '0);
    deq         = inst_valid && bus.inst_ready_id && !flush;
    pc_en       = reset_n && (fire || flush);
    next_pc_if1 = flush ? flush_target : current_pc_if1 + 32'd4;
  end

  always_comb begin
    outst_d    = outst_q + OUTST_W'(fire) - OUTST_W'(rsp);
    drop_cnt_d = drop_cnt_q;
    if (flush) begin
      drop_cnt_d = outst_q - OUTST_W'(rsp);
    end else if (rsp && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - OUTST_W'(1);
    end

    pcq_wr_d = pcq_wr_q + PtrW'(fire);
    pcq_rd_d = pcq_rd_q + PtrW'(rsp);
    wr_ptr_d = wr_ptr_q + PtrW'(enq);
    rd_next  = rd_ptr_q + PtrW'(deq);
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      count_d  = count_q + CntW'(enq) - CntW'(deq);
      rd_ptr_d = rd_next;
    end

    // Head registers track the next head; they hold their last value once the FIFO drains.
    head_inst_d = head_inst_q;
    head_pc_d   = head_pc_q;
    if (count_d != '0) begin
      if (enq && (wr_ptr_q == rd_next)) begin
        head_inst_d = bus.imem_rsp_data;
        head_pc_d   = pcq_mem_q[pcq_rd_q];
      end else begin
        head_inst_d = inst_mem_q[rd_next];
        head_pc_d   = pc_mem_q[rd_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      head_inst_q <= '0;
      head_pc_q   <= '0;
      outst_q     <= '0;
      drop_cnt_q  <= '0;
      pcq_rd_q    <= '0;
      pcq_wr_q    <= '0;
    end else begin
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      head_inst_q <= head_inst_d;
      head_pc_q   <= head_pc_d;
      outst_q     <= outst_d;
      drop_cnt_q  <= drop_cnt_d;
      pcq_rd_q    <= pcq_rd_d;
      pcq_wr_q    <= pcq_wr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      inst_mem_q[wr_ptr_q] <= bus.imem_rsp_data;
      pc_mem_q[wr_ptr_q]   <= pcq_mem_q[pcq_rd_q];
    end
    if (fire) begin
      pcq_mem_q[pcq_wr_q] <= current_pc_if1;
    end
  end

  enq_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
                                    enq |-> (count_q != CntW'(FIFO_DEPTH)));

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else if (bus.inst_ready_id && !inst_valid && !flush && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_stall_cnt = stall_cnt_q;
`endif

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = current_pc_if1;
  assign bus.inst_valid_if2 = inst_valid;
  assign bus.inst_if2       = head_inst_q;
  assign bus.pc_if2         = head_pc_q;

endmodule

// File: tb/tb_if2_fetch_stage.sv
// tb_if2_fetch_stage: directed scoreboard bench; the bench owns the IF1 PC register and an
// in-order instruction memory whose latency each step can change.
module tb_if2_fetch_stage;
  localparam int unsigned Depth = 2;

  typedef struct {
    logic [31:0] addr;
    int unsigned epoch;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] current_pc_if1, next_pc_if1, flush_target;
  logic        pc_en, flush;
  logic        mem_ready, inst_ready_id, rsp_valid;
  logic [31:0] rsp_data;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] fetch_stall_cnt;
  logic [31:0] stall_model;
`endif

  if2_fetch_stage_if bus ();

  if2_fetch_stage #(
    .FIFO_DEPTH(Depth),
    .OUTST_W   (2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .current_pc_if1(current_pc_if1),
    .next_pc_if1   (next_pc_if1),
    .pc_en         (pc_en),
    .flush         (flush),
    .flush_target  (flush_target),
`ifdef FETCH_STALL_CNT_EN
    .fetch_stall_cnt(fetch_stall_cnt),
`endif
    .bus           (bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_req_ready = mem_ready;
  assign bus.imem_rsp_valid = rsp_valid;
  assign bus.imem_rsp_data  = rsp_data;
  assign bus.inst_ready_id  = inst_ready_id;

  req_t        pend[$];
  ent_t        sb[$];
  ent_t        last;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int unsigned epoch = 0;
  int          first_fire = -1;
  int          first_valid = -1;
  int          fires = 0;
  int          wraps = 0;
  bit          watch = 1'b0;
  bit          hit;
  logic [31:0] first_deq_pc = '0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive the memory response, check mid-cycle, then advance the models.
  task automatic cycle();
    bit          exp_req, exp_valid, fire, deq, keep, load_pc;
    req_t        r;
    ent_t        e;
    logic [31:0] pc_next;
    keep    = 1'b0;
    load_pc = 1'b0;
    pc_next = current_pc_if1;
    if (reset_n && (pend.size() != 0) && (pend[0].due <= cyc)) begin
      rsp_valid = 1'b1;
      rsp_data  = mem_data(pend[0].addr);
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = $urandom;
    end
    #4;
    if (!reset_n) begin
      chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
      chk("rst_pc_en", 32'(pc_en), 32'h0);
      pend.delete();
      sb.delete();
      last = '{pc: 32'h0, inst: 32'h0};
`ifdef FETCH_STALL_CNT_EN
      stall_model = '0;
`endif
    end else begin
      exp_valid = (sb.size() != 0);
      exp_req   = !flush && ((pend.size() + sb.size()) < Depth);
      fire      = exp_req && mem_ready;
      deq       = exp_valid && inst_ready_id && !flush;
      chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
      chk("inst_valid", 32'(bus.inst_valid_if2), 32'(exp_valid));
      if (exp_valid) last = sb[0];
      chk("pc_if2", bus.pc_if2, last.pc);
      chk("inst_if2", bus.inst_if2, last.inst);
      if (exp_valid && (first_valid < 0)) first_valid = cyc;
      chk("pc_en", 32'(pc_en), 32'(fire || flush));
      pc_next = flush ? flush_target : current_pc_if1 + 32'd4;
      load_pc = fire || flush;
      if (load_pc) chk("next_pc", next_pc_if1, pc_next);
      if (fire) begin
        chk("req_addr", bus.imem_req_addr, current_pc_if1);
        if (current_pc_if1 == 32'hFFFF_FFFC) begin
          chk("wrap_next_pc", next_pc_if1, 32'h0);
          wraps++;
        end
        if (first_fire < 0) first_fire = cyc;
        fires++;
      end
`ifdef FETCH_STALL_CNT_EN
      chk("stall_cnt", fetch_stall_cnt, stall_model);
      if (inst_ready_id && !exp_valid && !flush && (stall_model != 32'hFFFF_FFFF)) stall_model++;
`endif
      if (rsp_valid) begin
        r    = pend.pop_front();
        keep = (r.epoch == epoch) && !flush;
      end
      if (deq) begin
        if (watch) begin
          first_deq_pc = sb[0].pc;
          watch = 1'b0;
        end
        e = sb.pop_front();
      end
      if (keep) sb.push_back('{pc: r.addr, inst: mem_data(r.addr)});
      if (flush) begin
        sb.delete();
        epoch++;
      end
      if (fire) pend.push_back('{addr: current_pc_if1, epoch: epoch, due: cyc + lat});
    end
    @(posedge clk);
    #1;
    if (load_pc) current_pc_if1 = pc_next;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    flush          = 1'b0;
    flush_target   = '0;
    mem_ready      = 1'b1;
    inst_ready_id  = 1'b1;
    rsp_valid      = 1'b0;
    rsp_data       = '0;
    current_pc_if1 = 32'hFFFF_F000;
    last           = '{pc: 32'h0, inst: 32'h0};
`ifdef FETCH_STALL_CNT_EN
    stall_model = '0;
`endif
    @(posedge clk);
    #1;
    repeat (3) cycle();
    reset_n = 1'b1;

    // Streaming from 0xFFFFF000, 1-cycle memory latency, decode always ready.
    repeat (12) cycle();
    chk("first_latency", 32'(first_valid - first_fire), 32'd2);

    // Memory ready toggling.
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0];
      cycle();
    end
    mem_ready = 1'b1;

    // Empty the pipe, then hold decode off for 6 cycles.
    flush_target = 32'h0000_2000;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    mem_ready = 1'b0;
    repeat (4) cycle();
    mem_ready = 1'b1;
    inst_ready_id = 1'b0;
    fires = 0;
    repeat (6) cycle();
    chk("bp_fires", 32'(fires), 32'd2);
    inst_ready_id = 1'b1;
    repeat (10) cycle();

    // Flush with two requests in flight.
    lat = 3;
    for (int i = 0; (i < 20) && (pend.size() != 2); i++) cycle();
    chk("two_in_flight", 32'(pend.size()), 32'd2);
    flush_target = 32'h0000_0100;
    flush = 1'b1;
    watch = 1'b1;
    first_deq_pc = '0;
    cycle();
    flush = 1'b0;
    chk("flush_pc_loaded", current_pc_if1, 32'h0000_0100);
    repeat (14) cycle();
    chk("post_flush_pc", first_deq_pc, 32'h0000_0100);

    // Flush on the same cycle as a response and a decode handshake.
    lat = 1;
    for (int i = 0; (i < 20) &&
         !((sb.size() != 0) && (pend.size() != 0) && (pend[0].due <= cyc)); i++) cycle();
    hit = (sb.size() != 0) && (pend.size() != 0) && (pend[0].due <= cyc);
    chk("flush_rsp_setup", 32'(hit), 32'd1);
    flush_target = 32'h0000_3000;
    flush = 1'b1;
    watch = 1'b1;
    first_deq_pc = '0;
    cycle();
    flush = 1'b0;
    chk("flush_rsp_empty", 32'(bus.inst_valid_if2), 32'h0);
    repeat (10) cycle();
    chk("flush_rsp_first_pc", first_deq_pc, 32'h0000_3000);

    // Address wrap.
    flush_target = 32'hFFFF_FFF8;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    repeat (10) cycle();
    chk("wrap_seen", 32'(wraps != 0), 32'd1);

    // Reset mid-operation with requests in flight.
    lat = 2;
    repeat (5) cycle();
    reset_n = 1'b0;
    repeat (2) cycle();
    current_pc_if1 = 32'h0000_4000;
    reset_n = 1'b1;
    repeat (10) cycle();

    // Long latency with decode ready: empty cycles stall, a flush cycle does not.
    lat = 3;
    repeat (8) cycle();
    flush_target = 32'h0000_5000;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    repeat (10) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
